// File: rtl/mux_arbiter.sv
// Round-robin arbiter granting one of 2**SELECT_WIDTH requesters a shared mux path.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of continuous ownership.
module mux_arbiter #(
    parameter int WIDTH        = 16,
    parameter int SELECT_WIDTH = 2,
    parameter int MAX_HOLD     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2**SELECT_WIDTH-1:0]    request,
    input  logic [WIDTH-1:0]              data_in [2**SELECT_WIDTH],
    output logic [2**SELECT_WIDTH-1:0]    grant,
    output logic [SELECT_WIDTH-1:0]       index,
    output logic                          busy,
    output logic [WIDTH-1:0]              data_out,
    output logic                          timeout
);

    localparam int N = 2**SELECT_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_arbiter: MAX_HOLD must be in 2..255");
    end

    logic [0:0]              state_q;
    logic [SELECT_WIDTH-1:0] ptr_q;
    logic [SELECT_WIDTH-1:0] index_q;
    logic [N-1:0]            grant_q;
    logic [SELECT_WIDTH-1:0] winner;
    logic [SELECT_WIDTH-1:0] cand;
    logic                    force_rel;

    // First set request bit scanning upward from ptr; index arithmetic wraps mod N.
    always_comb begin
        winner = ptr_q;
        cand   = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr_q + SELECT_WIDTH'(i);
            if (request[cand]) begin
                winner = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    assign force_rel = (hold_cnt_q == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= (state_q == BUSY) && force_rel && request[index_q];
            if (state_q == BUSY) begin
                hold_cnt_q <= hold_cnt_q + 8'd1;
            end else begin
                hold_cnt_q <= 8'd0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            index_q <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|request) begin
                        index_q <= winner;
                        grant_q <= N'(1) << winner;
                        state_q <= BUSY;
                    end
                end
                default: begin
                    // Release always passes through IDLE, so new requests wait one edge.
                    if (!request[index_q] || force_rel) begin
                        grant_q <= '0;
                        ptr_q   <= index_q + SELECT_WIDTH'(1);
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign index    = index_q;
    assign busy     = (state_q == BUSY);
    assign data_out = busy ? data_in[index_q] : '0;

endmodule
